// File: rtl/dma_pump.sv
// dma_pump: register-controlled DMA pattern source feeding the tlp_xcvr stream port
module dma_pump #(
  parameter int REG_ABITS = 3
) (
  input  logic                 pcieClk_in,
  input  logic                 reset_in,
  input  logic [REG_ABITS-1:0] cpuChan_in,
  input  logic [31:0]          cpuWrData_in,
  input  logic                 cpuWrValid_in,
  output logic                 cpuWrReady_out,
  output logic [31:0]          cpuRdData_out,
  output logic                 cpuRdValid_out,
  input  logic                 cpuRdReady_in,
  output logic [63:0]          dmaData_out,
  output logic                 dmaValid_out,
  input  logic                 dmaReady_in
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state, state_nx;
  logic [31:0] length, seed, step, sent, remaining, next_c;
  logic done, aborted, busy, start, abort, accept;
  logic launch, empty_done, end_done, end_abort;
  logic unused_rd_ready;
  assign unused_rd_ready = cpuRdReady_in;
  assign cpuWrReady_out  = 1'b1;
  assign cpuRdValid_out  = 1'b1;
  assign busy   = state != IDLE;
  assign start  = cpuWrValid_in && cpuChan_in == REG_ABITS'(0) && cpuWrData_in[0];
  assign abort  = cpuWrValid_in && cpuChan_in == REG_ABITS'(0) && cpuWrData_in[1];
  assign accept = dmaValid_out && dmaReady_in;
  assign next_c = dmaData_out[63:32] + step;
  assign cpuRdData_out = cpuChan_in == REG_ABITS'(1) ? length :
                         cpuChan_in == REG_ABITS'(2) ? seed :
                         cpuChan_in == REG_ABITS'(3) ? step :
                         cpuChan_in == REG_ABITS'(4) ? {29'd0, aborted, done, busy} :
                         cpuChan_in == REG_ABITS'(5) ? sent : 32'd0;
  // state register
  always_ff @(posedge pcieClk_in or posedge reset_in)
    if (reset_in) state <= IDLE;
    else state <= state_nx;
  // next state and one-cycle control strobes; ABORT outranks START once busy
  always_comb begin
    state_nx   = state;
    launch     = 1'b0;
    empty_done = 1'b0;
    end_done   = 1'b0;
    end_abort  = 1'b0;
    case (state)
      IDLE: begin
        launch     = start && length != 0;
        empty_done = start && length == 0;
        state_nx   = launch ? RUN : IDLE;
      end
      RUN: begin
        end_abort = abort && (accept || !dmaValid_out);
        end_done  = !abort && accept && remaining == 32'd1;
        state_nx  = (end_abort || end_done) ? IDLE : abort ? STOPPING : RUN;
      end
      STOPPING: begin
        end_abort = accept;
        state_nx  = accept ? IDLE : STOPPING;
      end
      default: state_nx = IDLE;
    endcase
  end
  // register file, beat counters and the registered stream output
  always_ff @(posedge pcieClk_in or posedge reset_in)
    if (reset_in) begin
      length       <= 32'd0;
      seed         <= 32'd0;
      step         <= 32'd1;
      sent         <= 32'd0;
      remaining    <= 32'd0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      dmaValid_out <= 1'b0;
      dmaData_out  <= 64'd0;
    end else begin
      if (cpuWrValid_in && !busy && cpuChan_in == REG_ABITS'(1)) length <= cpuWrData_in;
      if (cpuWrValid_in && !busy && cpuChan_in == REG_ABITS'(2)) seed <= cpuWrData_in;
      if (cpuWrValid_in && !busy && cpuChan_in == REG_ABITS'(3)) step <= cpuWrData_in;
      if (accept) begin
        sent        <= sent + 32'd1;
        remaining   <= remaining - 32'd1;
        dmaData_out <= {next_c, ~next_c};
      end
      if (launch) begin
        done         <= 1'b0;
        aborted      <= 1'b0;
        sent         <= 32'd0;
        remaining    <= length;
        dmaValid_out <= 1'b1;
        dmaData_out  <= {seed, ~seed};
      end
      if (empty_done) begin
        done    <= 1'b1;
        aborted <= 1'b0;
        sent    <= 32'd0;
      end
      if (end_done) begin
        dmaValid_out <= 1'b0;
        done         <= 1'b1;
      end
      if (end_abort) begin
        dmaValid_out <= 1'b0;
        aborted      <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dma_pump.sv
// tb_dma_pump: randomized scoreboard bench for dma_pump
module tb_dma_pump;
  logic clk = 1'b0, rst;
  logic [2:0] chan;
  logic [31:0] wdata, rdata;
  logic wvalid, wready, rvalid, rready, valid, ready;
  logic [63:0] data;
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [31:0] m_len, m_seed, m_step;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;
  bit pat[6] = '{1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  dma_pump #(.REG_ABITS(3)) dut (
    .pcieClk_in(clk), .reset_in(rst), .cpuChan_in(chan), .cpuWrData_in(wdata),
    .cpuWrValid_in(wvalid), .cpuWrReady_out(wready), .cpuRdData_out(rdata),
    .cpuRdValid_out(rvalid), .cpuRdReady_in(rready), .dmaData_out(data),
    .dmaValid_out(valid), .dmaReady_in(ready)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [31:0] d);
    chan = ch; wdata = d; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] ch, input logic [31:0] exp);
    chan = ch;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic cfg(input logic [31:0] len, input logic [31:0] sd, input logic [31:0] st);
    wr(3'd1, len); wr(3'd2, sd); wr(3'd3, st);
    m_len = len; m_seed = sd; m_step = st;
  endtask

  // reference: beat n carries c = SEED + n*STEP (mod 2^32) as {c, ~c}
  task automatic start_xfer();
    logic [31:0] c;
    for (int n = 0; n < int'(m_len); n++) begin
      c = m_seed + 32'(n) * m_step;
      q.push_back({c, ~c});
    end
    wr(3'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    chan = 3'd4;
    #1;
    while (rdata[0] && n < budget) begin
      if (rnd) ready = 1'($urandom % 2);
      step();
      n++;
    end
    check("idle_timeout", 64'(rdata[0]), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);
  endtask

  // monitor: every accepted beat is popped and compared; stalled beats must hold
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", 64'(valid), 64'd1);
        check("hold_data", data, prev_data);
      end
      if (valid && ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got %h expected no beat", data);
        end else check("beat", data, q.pop_front());
      end
      prev_stall = valid && !ready;
      prev_data = data;
    end
  end

  initial begin
    rst = 1'b1; chan = 3'd0; wdata = 32'd0; wvalid = 1'b0; ready = 1'b0; rready = 1'b1;
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", data, 64'd0);
    check("wr_ready", 64'(wready), 64'd1);
    check("rd_valid", 64'(rvalid), 64'd1);
    rd("rst_status", 3'd4, 32'd0);
    rd("rst_sent", 3'd5, 32'd0);
    rd("rst_step", 3'd3, 32'd1);
    rd("rst_len", 3'd1, 32'd0);
    rd("unused_ch7", 3'd7, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // basic run at full throughput
    cfg(32'd4, 32'h10, 32'd1);
    ready = 1'b1;
    start_xfer();
    check("first_valid", 64'(valid), 64'd1);
    check("first_data", data, 64'h00000010_FFFFFFEF);
    repeat (4) step();
    check("basic_end_valid", 64'(valid), 64'd0);
    rd("basic_status", 3'd4, 32'd2);
    rd("basic_sent", 3'd5, 32'd4);
    rd("ctrl_reads0", 3'd0, 32'd0);
    wr(3'd0, 32'd2);
    rd("idle_abort_status", 3'd4, 32'd2);
    // backpressure
    cfg(32'd3, $urandom, $urandom);
    start_xfer();
    for (int i = 0; i < 6; i++) begin
      ready = pat[i];
      step();
    end
    rd("bp_status", 3'd4, 32'd2);
    rd("bp_sent", 3'd5, 32'd3);
    check("bp_queue", 64'(q.size()), 64'd0);
    // counter wrap
    cfg(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1);
    cfg(32'd3, 32'hFFFF_FFFE, 32'd1);
    ready = 1'b1;
    start_xfer();
    wait_idle(20, 1'b0);
    rd("wrap_sent", 3'd5, 32'd3);
    // abort while stalled
    cfg(32'd100, $urandom, $urandom);
    ready = 1'b1;
    start_xfer();
    repeat (5) step();
    ready = 1'b0;
    wr(3'd0, 32'd2);
    rd("stopping_busy", 3'd4, 32'd1);
    repeat (2) step();
    ready = 1'b1;
    step();
    check("abort_valid", 64'(valid), 64'd0);
    rd("abort_status", 3'd4, 32'd4);
    rd("abort_sent", 3'd5, 32'd6);
    check("abort_left", 64'(q.size()), 64'd94);
    q.delete();
    // zero length
    cfg(32'd0, $urandom, $urandom);
    start_xfer();
    check("len0_valid", 64'(valid), 64'd0);
    rd("len0_status", 3'd4, 32'd2);
    rd("len0_sent", 3'd5, 32'd0);
    // START and register writes during a run are ignored
    cfg(32'd8, $urandom, $urandom);
    ready = 1'b1;
    start_xfer();
    wr(3'd0, 32'd1);
    wr(3'd2, ~m_seed);
    wr(3'd1, 32'd5);
    wait_idle(30, 1'b0);
    rd("busy_seed", 3'd2, m_seed);
    rd("busy_len", 3'd1, 32'd8);
    rd("busy_sent", 3'd5, 32'd8);
    // randomized transfers with random backpressure
    repeat (20) begin
      cfg($urandom_range(1, 12), $urandom, $urandom);
      start_xfer();
      wait_idle(400, 1'b1);
      rd("rand_status", 3'd4, 32'd2);
      rd("rand_sent", 3'd5, m_len);
    end
    // asynchronous reset during beat 2
    cfg(32'd10, $urandom, 32'd3);
    ready = 1'b1;
    start_xfer();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(valid), 64'd0);
    check("rst_mid_data", data, 64'd0);
    check("rst_mid_left", 64'(q.size()), 64'd8);
    q.delete();
    step();
    rd("rst_mid_status", 3'd4, 32'd0);
    rd("rst_mid_sent", 3'd5, 32'd0);
    rd("rst_mid_step", 3'd3, 32'd1);
    rst = 1'b0;
    // recovers after reset
    cfg(32'd2, $urandom, $urandom);
    start_xfer();
    wait_idle(20, 1'b0);
    rd("post_rst_sent", 3'd5, 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_pump.md
Name: dma_pump

Overview:
- Register-controlled DMA stream source: the FPGA-initiated transmit direction, complementing the CPU-initiated register read/write path.
- Exposes a small register file on the tlp_xcvr internal cpuChan/cpuWr/cpuRd interface.
- On command, emits a programmed number of 64-bit pattern words into the tlp_xcvr dmaData/dmaValid/dmaReady stream port. Used for host DMA bring-up and throughput measurement.

Parameters:
REG_ABITS, 3, register channel address width; channels 0-5 used, 6-7 read 0 and ignore writes.

Ports:
pcieClk_in  in  1  125MHz PCIe clock; sole clock.
reset_in  in  1  reset, asynchronous, active-high.
cpuChan_in  in  REG_ABITS  register channel for read and write.
cpuWrData_in  in  32  write data.
cpuWrValid_in  in  1  write strobe.
cpuWrReady_out  out  1  always 1.
cpuRdData_out  out  32  read data for cpuChan_in, combinational.
cpuRdValid_out  out  1  always 1.
cpuRdReady_in  in  1  unused; read side effects are forbidden.
dmaData_out  out  64  stream data.
dmaValid_out  out  1  stream valid.
dmaReady_in  in  1  stream ready from tlp_xcvr.

Behaviour:
- Register map:
  - ch0 CTRL, write-only, self-clearing: bit0 START, bit1 ABORT; reads 0.
  - ch1 LENGTH: word count, 32-bit. Reset 0.
  - ch2 SEED: initial pattern counter. Reset 0.
  - ch3 STEP: pattern increment. Reset 1.
  - ch4 STATUS, read-only: bit0 BUSY, bit1 DONE (sticky), bit2 ABORTED (sticky); other bits 0.
  - ch5 SENT, read-only: words accepted since last START. Reset 0.
- Writes to ch1-3 while BUSY are ignored.
- Reset values: dmaValid_out=0, dmaData_out=0, FSM=IDLE, all counters and sticky bits 0.
- Reset asserted mid-transfer aborts immediately. No beat completes on the reset cycle.
- Pattern: internal 32-bit counter c.
  - Beat n: c = SEED + n*STEP, modulo 2^32 (wraps silently).
  - dmaData_out = {c, ~c}.
- A beat transfers on a rising edge where dmaValid_out && dmaReady_in.
- While dmaValid_out=1 and dmaReady_in=0, dmaData_out and dmaValid_out hold stable. Valid is never retracted before acceptance.
- dmaValid_out and dmaData_out are registered; no combinational path from dmaReady_in.
- FSM IDLE:
  - START with LENGTH!=0: next cycle BUSY=1, DONE=0, ABORTED=0, SENT=0, remaining=LENGTH, c=SEED, dmaValid_out=1 with beat 0. Go to RUN.
  - START with LENGTH=0: DONE=1, ABORTED=0, SENT=0 next cycle; no beats; stay IDLE.
  - ABORT in IDLE: no effect.
- FSM RUN:
  - On each accepted beat: SENT+=1, remaining-=1, c+=STEP.
  - If remaining becomes 0: dmaValid_out=0, BUSY=0, DONE=1, go to IDLE.
  - Otherwise present the next beat the following cycle with no bubble. Sustained throughput is 1 word/cycle when ready is held high.
- ABORT in RUN:
  - If a beat is accepted the same cycle or dmaValid_out=0: next cycle dmaValid_out=0, ABORTED=1, BUSY=0, go to IDLE. The accepted beat is counted in SENT.
  - Otherwise go to STOPPING.
- FSM STOPPING: keep the current beat valid until accepted. Then SENT+=1, dmaValid_out=0, ABORTED=1, BUSY=0, go to IDLE.
- START while BUSY is ignored.
- START and ABORT set in the same write: ABORT wins if BUSY; START wins if IDLE.
- DONE and ABORTED are never both set by one transfer.
- Latency: START write cycle to first dmaValid_out=1 is 1 cycle.
- STATUS and SENT reads reflect register state as of the current cycle.

Test Plan:
- Basic run: LENGTH=4, SEED=0x10, STEP=1, START, ready held 1 -> 4 consecutive beats {0x10,0xFFFFFFEF}..{0x13,0xFFFFFFEC}; then valid=0, STATUS=0x2, SENT=4.
- Backpressure: LENGTH=3, ready toggling 1,0,0,1,0,1 -> data/valid stable during ready=0; exactly 3 beats, in order, no duplicates; DONE=1.
- Wrap: SEED=0xFFFFFFFE, STEP=1, LENGTH=3 -> upper words 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Abort under stall: LENGTH=100, ready=1 for 5 cycles, then ready=0 and write ABORT, then ready=1 after 3 cycles -> exactly 6 beats total, SENT=6, STATUS=0x4.
- Edge commands: LENGTH=0 + START -> no valid, STATUS=0x2. START during RUN and SEED write during RUN -> ignored; transfer pattern unchanged.
- Reset mid-run: assert reset_in asynchronously during beat 2 -> dmaValid_out=0 immediately; STATUS=0, SENT=0, STEP reads 1.
